// File: rtl/module1_tx_pkg.sv
// Shared types, STF period ROM and Q1.15 rounding/saturation helper for the module1 TX path.
package module1_tx_pkg;

  localparam int STF_LEN = 16;

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t i;
    sample_t q;
  } cplx_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One 16-sample period of the 802.11a/g short training symbol, Q1.15.
  function automatic cplx_t stf_rom(input logic [3:0] idx);
    cplx_t c;
    case (idx)
      4'd0:    c = cplx_t'{16'sd1507, 16'sd1507};
      4'd1:    c = cplx_t'{-16'sd4325, 16'sd66};
      4'd2:    c = cplx_t'{-16'sd426, -16'sd2589};
      4'd3:    c = cplx_t'{16'sd4686, -16'sd426};
      4'd4:    c = cplx_t'{16'sd3015, 16'sd0};
      4'd5:    c = cplx_t'{16'sd4686, -16'sd426};
      4'd6:    c = cplx_t'{-16'sd426, -16'sd2589};
      4'd7:    c = cplx_t'{-16'sd4325, 16'sd66};
      4'd8:    c = cplx_t'{16'sd1507, 16'sd1507};
      4'd9:    c = cplx_t'{16'sd66, -16'sd4325};
      4'd10:   c = cplx_t'{-16'sd2589, -16'sd426};
      4'd11:   c = cplx_t'{-16'sd426, 16'sd4686};
      4'd12:   c = cplx_t'{16'sd0, 16'sd3015};
      4'd13:   c = cplx_t'{-16'sd426, 16'sd4686};
      4'd14:   c = cplx_t'{-16'sd2589, -16'sd426};
      4'd15:   c = cplx_t'{16'sd66, -16'sd4325};
      default: c = cplx_t'{16'sd0, 16'sd0};
    endcase
    return c;
  endfunction

  // Round half up at bit 15, then clamp to the Q1.15 range.
  function automatic sample_t sat_round_q15(input logic signed [31:0] p);
    logic signed [31:0] r;
    sample_t y;
    r = (p + 32'sd16384) >>> 15;
    if (r > 32'sd32767) begin
      y = 16'sd32767;
    end else if (r < -32'sd32768) begin
      y = -16'sd32768;
    end else begin
      y = r[15:0];
    end
    return y;
  endfunction

endpackage

// File: rtl/module1_stf_preamble_gen_if.sv
// AXI4-Stream sample bus of the STF generator; tdata = {Q, I}.
interface module1_stf_preamble_gen_if #(
  parameter int DATA_W = 16
);
  logic [2*DATA_W-1:0] tdata;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/module1_cmul_q15_round.sv
// Real x Q1.15 scale of one component with round-half-up and saturation.
module module1_cmul_q15_round
  import module1_tx_pkg::*;
(
  input  sample_t i_a,
  input  sample_t i_b,
  output sample_t o_y
);

  logic signed [31:0] w_prod;

  assign w_prod = $signed({{16{i_a[15]}}, i_a}) * $signed({{16{i_b[15]}}, i_b});
  assign o_y    = sat_round_q15(w_prod);

endmodule

// File: rtl/module1_stf_preamble_gen.sv
// 802.11a/g STF burst generator: NUM_PERIODS x 16 gain-scaled samples on AXI4-Stream.
// Optional build macro STF_WINDOW_EN halves the first and last sample of each burst.
module module1_stf_preamble_gen
  import module1_tx_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_PERIODS = 10,
  parameter int PERIOD_LEN  = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] gain,
  output logic                     busy,
  output logic                     done,
  module1_stf_preamble_gen_if.master m_axis
);

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_idx, w_idx_nxt, r_per, w_per_nxt;
  sample_t             r_gain, w_gain_nxt;
  logic [2*DATA_W-1:0] r_tdata, w_tdata_nxt;
  logic                r_tvalid, w_tvalid_nxt, r_tlast, w_tlast_nxt;
  logic                r_busy, w_busy_nxt, r_done, w_done_nxt;

  logic [3:0]          w_nidx, w_nper;
  logic                w_is_last, w_load;
  sample_t             w_gain_sel, w_y_i, w_y_q, w_win_i, w_win_q;
  cplx_t               w_rom;

  // Coordinates of the sample to load next; from IDLE the burst restarts at sample 0.
  always_comb begin
    w_nidx = 4'd0;
    w_nper = 4'd0;
    if (r_state == ST_RUN) begin
      w_nidx = r_idx + 4'd1;
      w_nper = (r_idx == 4'(PERIOD_LEN - 1)) ? (r_per + 4'd1) : r_per;
    end else begin
      w_nidx = 4'd0;
      w_nper = 4'd0;
    end
  end

  assign w_is_last  = (w_nper == 4'(NUM_PERIODS - 1)) && (w_nidx == 4'(PERIOD_LEN - 1));
  assign w_gain_sel = (r_state == ST_IDLE) ? sample_t'(gain) : r_gain;
  assign w_rom      = stf_rom(w_nidx);

  module1_cmul_q15_round u_cmul_i (.i_a(w_rom.i), .i_b(w_gain_sel), .o_y(w_y_i));
  module1_cmul_q15_round u_cmul_q (.i_a(w_rom.q), .i_b(w_gain_sel), .o_y(w_y_q));

`ifdef STF_WINDOW_EN
  logic w_edge;
  assign w_edge  = ((w_nidx == 4'd0) && (w_nper == 4'd0)) || w_is_last;
  assign w_win_i = w_edge ? (w_y_i >>> 1) : w_y_i;
  assign w_win_q = w_edge ? (w_y_q >>> 1) : w_y_q;
`else
  assign w_win_i = w_y_i;
  assign w_win_q = w_y_q;
`endif

  assign w_load = !r_tvalid || m_axis.tready;

  // Next-state and output-register decode; the output stage only moves when free or consumed.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_per_nxt    = r_per;
    w_gain_nxt   = r_gain;
    w_tdata_nxt  = r_tdata;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_RUN;
          w_gain_nxt   = sample_t'(gain);
          w_idx_nxt    = w_nidx;
          w_per_nxt    = w_nper;
          w_tdata_nxt  = {w_win_q, w_win_i};
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = w_is_last;
          w_busy_nxt   = 1'b1;
        end else begin
          w_busy_nxt   = 1'b0;
        end
      end
      ST_RUN: begin
        if (r_tvalid && m_axis.tready && r_tlast) begin
          w_state_nxt  = ST_IDLE;
          w_idx_nxt    = 4'd0;
          w_per_nxt    = 4'd0;
          w_tvalid_nxt = 1'b0;
          w_tlast_nxt  = 1'b0;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
        end else if (w_load) begin
          w_idx_nxt    = w_nidx;
          w_per_nxt    = w_nper;
          w_tdata_nxt  = {w_win_q, w_win_i};
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = w_is_last;
        end else begin
          w_tvalid_nxt = r_tvalid;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= 4'd0;
      r_per    <= 4'd0;
      r_gain   <= 16'sd0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_per    <= w_per_nxt;
      r_gain   <= w_gain_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tlast  <= w_tlast_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_module1_stf_preamble_gen.sv
// Self-checking bench for module1_stf_preamble_gen: spec vectors plus a reference model of the STF burst.
module tb_module1_stf_preamble_gen;

  localparam int TOTAL = 160;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic               start  = 1'b0;
  logic signed [15:0] gain   = 16'sd0;
  logic               busy, done;

  module1_stf_preamble_gen_if #(.DATA_W(16)) m_axis ();

  module1_stf_preamble_gen #(.DATA_W(16), .NUM_PERIODS(10), .PERIOD_LEN(16)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .start  (start),
    .gain   (gain),
    .busy   (busy),
    .done   (done),
    .m_axis (m_axis)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  int rom_i [16] = '{1507, -4325, -426, 4686, 3015, 4686, -426, -4325,
                     1507, 66, -2589, -426, 0, -426, -2589, 66};
  int rom_q [16] = '{1507, 66, -2589, -426, 0, -426, -2589, 66,
                     1507, -4325, -426, 4686, 3015, 4686, -426, -4325};

  logic signed [15:0] cap_i [TOTAL];
  logic signed [15:0] cap_q [TOTAL];
  logic               cap_last [TOTAL];
  int                 nbeats, ndone;

  typedef struct {
    int gain;
    int beat;
    int ei;
    int eq;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  // Expected component of burst sample 'beat': round-half-up of rom*gain/2^15, clamped, edge-windowed.
  function automatic int ref_comp(input int beat, input int g, input bit is_q);
    longint base, y;
    base = is_q ? longint'(rom_q[beat % 16]) : longint'(rom_i[beat % 16]);
    y = floor_div(base * g + 16384, 32768);
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
`ifdef STF_WINDOW_EN
    if (beat == 0 || beat == TOTAL - 1) y = floor_div(y, 2);
`endif
    return int'(y);
  endfunction

  task automatic run_burst(input int g, input bit rnd, input int pulse_at);
    int cyc, extra;
    logic [31:0] pd;
    logic pl, ps;
    bit pulsed;
    nbeats = 0; ndone = 0; ps = 1'b0; pulsed = 1'b0; cyc = 0; pd = 32'd0; pl = 1'b0;
    @(negedge ap_clk);
    gain = 16'(g); start = 1'b1; m_axis.tready = 1'b1;
    @(negedge ap_clk);
    start = 1'b0; gain = 16'($urandom);
    chk("latency_tvalid", longint'(m_axis.tvalid), 1);
    chk("busy_set", longint'(busy), 1);
    while (nbeats < TOTAL && cyc < 4000) begin
      if (ps) begin
        chk("stall_data", longint'(m_axis.tdata), longint'(pd));
        chk("stall_last", longint'(m_axis.tlast), longint'(pl));
        chk("stall_valid", longint'(m_axis.tvalid), 1);
      end
      m_axis.tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = 1'b0;
      if (pulse_at >= 0 && nbeats == pulse_at && !pulsed) begin
        start = 1'b1; pulsed = 1'b1;
      end
      if (m_axis.tvalid && m_axis.tready) begin
        cap_i[nbeats]    = m_axis.tdata[15:0];
        cap_q[nbeats]    = m_axis.tdata[31:16];
        cap_last[nbeats] = m_axis.tlast;
        nbeats++;
      end
      ps = m_axis.tvalid && !m_axis.tready;
      pd = m_axis.tdata; pl = m_axis.tlast;
      @(negedge ap_clk);
      cyc++;
      if (done) ndone++;
    end
    start = 1'b0;
    chk("beat_count", nbeats, TOTAL);
    if (!rnd) chk("no_bubbles_cycles", cyc, TOTAL);
    chk("done_after_last", longint'(done), 1);
    chk("busy_clear", longint'(busy), 0);
    chk("tvalid_clear", longint'(m_axis.tvalid), 0);
    chk("tlast_clear", longint'(m_axis.tlast), 0);
    extra = 0;
    repeat (4) begin
      @(negedge ap_clk);
      if (done) ndone++;
      if (m_axis.tvalid) extra++;
    end
    chk("done_count", ndone, 1);
    chk("idle_no_valid", extra, 0);
  endtask

  task automatic compare_all(input int g);
    for (int b = 0; b < TOTAL; b++) begin
      chk($sformatf("beat%0d_i", b), longint'(cap_i[b]), ref_comp(b, g, 1'b0));
      chk($sformatf("beat%0d_q", b), longint'(cap_q[b]), ref_comp(b, g, 1'b1));
      chk($sformatf("beat%0d_last", b), longint'(cap_last[b]), (b == TOTAL - 1) ? 1 : 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rg;
    logic signed [15:0] t;
`ifdef STF_WINDOW_EN
    vecs[0] = '{32767, 0, 753, 753};
    vecs[2] = '{32767, 159, 33, -2163};
`else
    vecs[0] = '{32767, 0, 1507, 1507};
    vecs[2] = '{32767, 159, 66, -4325};
`endif
    vecs[1] = '{32767, 4, 3015, 0};
    vecs[3] = '{16384, 1, -2162, 33};
    vecs[4] = '{16384, 17, -2162, 33};
    vecs[5] = '{16384, 16, 754, 754};
    vecs[6] = '{-32768, 4, -3015, 0};

    m_axis.tready = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_tvalid", longint'(m_axis.tvalid), 0);
    chk("rst_tlast", longint'(m_axis.tlast), 0);
    chk("rst_tdata", longint'(m_axis.tdata), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    ap_rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_burst(vecs[v].gain, 1'b0, -1);
      chk($sformatf("vec%0d_i", v), longint'(cap_i[vecs[v].beat]), vecs[v].ei);
      chk($sformatf("vec%0d_q", v), longint'(cap_q[vecs[v].beat]), vecs[v].eq);
      compare_all(vecs[v].gain);
    end

    // Backpressure with the full-scale gain, then random gains.
    run_burst(32767, 1'b1, -1);
    compare_all(32767);
    for (int r = 0; r < 3; r++) begin
      t = 16'($urandom);
      rg = int'(t);
      run_burst(rg, 1'b1, -1);
      compare_all(rg);
    end

    // start pulsed mid-burst is ignored.
    run_burst(32767, 1'b0, 50);
    compare_all(32767);

    // Reset mid-burst abandons the burst; a fresh start begins at sample 0.
    @(negedge ap_clk);
    gain = 16'sh7FFF; start = 1'b1; m_axis.tready = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    repeat (80) @(negedge ap_clk);
    chk("midburst_active", longint'(m_axis.tvalid), 1);
    ap_rst = 1'b1;
    #1;
    chk("arst_tvalid", longint'(m_axis.tvalid), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_tlast", longint'(m_axis.tlast), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    ndone = 0;
    repeat (3) begin
      @(negedge ap_clk);
      if (done || m_axis.tvalid) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    run_burst(32767, 1'b0, -1);
    chk("restart_beat0_i", longint'(cap_i[0]), ref_comp(0, 32767, 1'b0));
    chk("restart_beat0_q", longint'(cap_q[0]), ref_comp(0, 32767, 1'b1));
    compare_all(32767);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
